// File: rtl/hammer_pkg.sv
// hammer_pkg: controller states, tester state encodings and the per-row result record
package hammer_pkg;
    typedef enum logic [2:0] {S_IDLE, S_ARM, S_RUN, S_CAPTURE, S_NEXT, S_DONE} state_t;
    localparam logic [3:0] TST_IDLE = 4'd0;
    localparam logic [3:0] TST_INIT = 4'd1;
    localparam logic [3:0] TST_HAMMER = 4'd2;
    localparam logic [3:0] TST_CHECK = 4'd3;
    localparam logic [3:0] TST_REPORT = 4'd4;
    localparam logic [3:0] TST_FINISH = 4'd5;
    localparam logic [3:0] TEST_FINISH_DEFAULT = TST_FINISH;
    localparam int ROW_WIDTH_DEF = 12;
    typedef struct packed {
        logic [ROW_WIDTH_DEF-1:0] row;
        logic [63:0] flips;
        logic timeout;
    } result_t;
endpackage

// File: rtl/hammer_campaign_ctrl_stats.sv
// campaign_stats: saturating flip total plus largest per-row count and its row
module campaign_stats
    import hammer_pkg::*;
#(
    parameter int ROW_WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 update,
    input  logic [ROW_WIDTH-1:0] row,
    input  logic [63:0]          flips,
    output logic [63:0]          total_flips,
    output logic [63:0]          max_flips,
    output logic [ROW_WIDTH-1:0] max_row
);
    logic [64:0] sum;
    assign sum = {1'b0, total_flips} + {1'b0, flips};
    // strict compare keeps the earliest row on ties
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            total_flips <= '0;
            max_flips <= '0;
            max_row <= '0;
        end else if (update) begin
            total_flips <= sum[64] ? '1 : sum[63:0];
            if (flips > max_flips) begin
                max_flips <= flips;
                max_row <= row;
            end
        end
    end
endmodule

// File: rtl/hammer_campaign_ctrl.sv
// hammer_campaign_ctrl: sweeps the row-hammer tester across a row range and gathers results
// Define HAMMER_CAMPAIGN_TIMEOUT_EN to build the per-row timeout counter.
module hammer_campaign_ctrl
    import hammer_pkg::*;
#(
    parameter int         ADDR_WIDTH  = 64,
    parameter int         ROW_WIDTH   = 12,
    parameter int         ROW_POS     = 10,
    parameter logic [3:0] TEST_FINISH = TEST_FINISH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] base_address,
    input  logic [ROW_WIDTH-1:0]  row_first,
    input  logic [ROW_WIDTH-1:0]  row_last,
    input  logic [ROW_WIDTH-1:0]  row_stride,
    input  logic [31:0]           timeout,
    output logic                  test_reset,
    output logic [ADDR_WIDTH-1:0] test_address,
    input  logic [3:0]            test_state,
    input  logic [63:0]           test_flips,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [ROW_WIDTH-1:0]  res_row,
    output logic [63:0]           res_flips,
    output logic                  res_timeout,
    output logic                  busy,
    output logic                  done,
    output logic [63:0]           total_flips,
    output logic [63:0]           max_flips,
    output logic [ROW_WIDTH-1:0]  max_row
);
    state_t state, state_nxt;
    logic [ROW_WIDTH-1:0] row_q, last_q, stride_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [63:0] flips_q;
    logic to_q, finish, timed_out, launch, handshake, nxt_stop;
    logic [ROW_WIDTH:0] nxt;

    assign finish = test_state == TEST_FINISH;
    assign launch = state == S_IDLE && start;
    assign handshake = state == S_CAPTURE && res_ready && !abort;
    assign nxt = {1'b0, row_q} + {1'b0, stride_q};
    assign nxt_stop = nxt[ROW_WIDTH] || nxt[ROW_WIDTH-1:0] > last_q;

`ifdef HAMMER_CAMPAIGN_TIMEOUT_EN
    logic [31:0] timeout_q, timer;
    always_ff @(posedge clk) begin
        if (!reset) begin
            timeout_q <= '0;
            timer <= '0;
        end else begin
            if (launch) timeout_q <= timeout;
            timer <= state == S_RUN ? timer + 32'd1 : 32'd0;
        end
    end
    assign timed_out = timeout_q != 32'd0 && timer == timeout_q - 32'd1;
`else
    logic unused_timeout;
    assign unused_timeout = ^timeout;
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start) state_nxt = row_first > row_last ? S_DONE : S_ARM;
            S_ARM:     state_nxt = S_RUN;
            S_RUN:     if (finish || timed_out) state_nxt = S_CAPTURE;
            S_CAPTURE: if (res_ready) state_nxt = S_NEXT;
            S_NEXT:    state_nxt = nxt_stop ? S_DONE : S_ARM;
            default:   state_nxt = S_IDLE;
        endcase
        if (abort && state != S_IDLE && state != S_DONE) state_nxt = S_DONE;
    end

    always_comb begin
        test_reset = state != S_RUN;
        res_valid = state == S_CAPTURE;
        busy = state != S_IDLE;
        done = state == S_DONE;
        res_row = row_q;
        res_flips = flips_q;
        res_timeout = to_q;
        test_address = base_q;
        test_address[ROW_POS +: ROW_WIDTH] = row_q;
    end

    // row_q only moves in IDLE and NEXT, so the address is stable from ARM to CAPTURE
    always_ff @(posedge clk) begin
        if (!reset) begin
            row_q <= '0;
            last_q <= '0;
            stride_q <= '0;
            base_q <= '0;
            flips_q <= '0;
            to_q <= 1'b0;
        end else begin
            if (launch) begin
                row_q <= row_first;
                last_q <= row_last;
                stride_q <= row_stride == '0 ? ROW_WIDTH'(1) : row_stride;
                base_q <= base_address;
            end
            if (state == S_RUN && (finish || timed_out)) begin
                flips_q <= test_flips;
                to_q <= !finish;
            end
            if (state == S_NEXT && !nxt_stop && !abort) row_q <= nxt[ROW_WIDTH-1:0];
        end
    end

    campaign_stats #(.ROW_WIDTH(ROW_WIDTH)) u_stats (
        .clk         (clk),
        .reset       (reset),
        .clear       (launch),
        .update      (handshake),
        .row         (row_q),
        .flips       (flips_q),
        .total_flips (total_flips),
        .max_flips   (max_flips),
        .max_row     (max_row)
    );
endmodule

// File: tb/tb_hammer_campaign_ctrl.sv
// tb_hammer_campaign_ctrl: vector table, directed corner sequences and random campaigns vs a sweep model
module tb_hammer_campaign_ctrl;
    import hammer_pkg::*;
    localparam int AW = 64, RW = 12, RP = 10;

    logic clk = 0, reset = 0, start = 0, abort = 0, res_ready = 0;
    logic [AW-1:0] base_address = '0;
    logic [RW-1:0] row_first = '0, row_last = '0, row_stride = '0;
    logic [31:0] timeout = '0;
    logic test_reset, res_valid, res_timeout, busy, done;
    logic [AW-1:0] test_address;
    logic [3:0] test_state = '0;
    logic [63:0] test_flips, res_flips, total_flips, max_flips;
    logic [RW-1:0] res_row, max_row, cur_row;

    int n_tests = 0, n_fail = 0, done_cnt = 0, run_cnt = 0, tcnt = 0;
    bit rdy_rand = 0, rdy_val = 1;
    result_t got_q[$];
    logic [63:0] flips_mem [0:4095];
    int fin_mem [0:4095];

    always #5 clk = ~clk;

    hammer_campaign_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .base_address(base_address), .row_first(row_first), .row_last(row_last),
        .row_stride(row_stride), .timeout(timeout), .test_reset(test_reset),
        .test_address(test_address), .test_state(test_state), .test_flips(test_flips),
        .res_valid(res_valid), .res_ready(res_ready), .res_row(res_row),
        .res_flips(res_flips), .res_timeout(res_timeout), .busy(busy), .done(done),
        .total_flips(total_flips), .max_flips(max_flips), .max_row(max_row)
    );

    // tester: reports FINISH fin_mem[row] cycles after release; 0 means it never finishes
    assign cur_row = test_address[RP +: RW];
    assign test_flips = flips_mem[cur_row];
    always @(posedge clk) begin
        if (test_reset) begin
            tcnt <= 0;
            test_state <= TST_IDLE;
        end else begin
            tcnt <= tcnt + 1;
            test_state <= (fin_mem[cur_row] != 0 && tcnt + 1 >= fin_mem[cur_row]) ? TST_FINISH : TST_HAMMER;
        end
    end

    function automatic logic [63:0] exp_addr(logic [63:0] b, logic [RW-1:0] r);
        logic [63:0] m;
        m = 64'hFFF << RP;
        return (b & ~m) | (64'(r) << RP);
    endfunction

    task automatic chk(string name, logic [127:0] got, logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // ready is driven before sampling so the handshake seen here is the one the DUT takes next edge
    initial forever begin
        @(negedge clk);
        res_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
        if (reset) begin
            if (res_valid && res_ready && !abort)
                got_q.push_back('{row: res_row, flips: res_flips, timeout: res_timeout});
            if (done) done_cnt++;
            if (!test_reset) run_cnt++;
            if (res_valid) chk("address", test_address, exp_addr(base_address, res_row));
        end
    end

    task automatic launch(int first, int last, int stride, int tmo);
        row_first = RW'(first);
        row_last = RW'(last);
        row_stride = RW'(stride);
        timeout = 32'(tmo);
        base_address = {$urandom, $urandom};
        got_q.delete();
        done_cnt = 0;
        run_cnt = 0;
        start = 1;
        tick;
        start = 0;
    endtask

    task automatic run_campaign(int first, int last, int stride, int tmo, string tag);
        result_t exp_q[$];
        logic [64:0] tot = '0;
        logic [63:0] mx = '0;
        logic [RW-1:0] mr = '0;
        int exp_run = 0, r = first;
        bit to;
        while (r <= last && r <= 4095) begin
            to = 0;
`ifdef HAMMER_CAMPAIGN_TIMEOUT_EN
            to = tmo != 0 && (fin_mem[r] == 0 || tmo - 1 < fin_mem[r]);
`endif
            exp_run += to ? tmo : fin_mem[r] + 1;
            exp_q.push_back('{row: RW'(r), flips: flips_mem[r], timeout: to});
            tot = tot + {1'b0, flips_mem[r]};
            if (tot[64]) tot = {1'b0, {64{1'b1}}};
            if (flips_mem[r] > mx) begin
                mx = flips_mem[r];
                mr = RW'(r);
            end
            r += stride == 0 ? 1 : stride;
        end
        launch(first, last, stride, tmo);
        for (int i = 0; i < 20000 && done_cnt == 0; i++) tick;
        tick;
        chk({tag, " done_pulses"}, 128'(done_cnt), 128'(1));
        chk({tag, " busy_after"}, 128'(busy), 128'(0));
        chk({tag, " records"}, 128'(got_q.size()), 128'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s rec%0d", tag, i), 128'(got_q[i]), 128'(exp_q[i]));
        chk({tag, " run_cycles"}, 128'(run_cnt), 128'(exp_run));
        chk({tag, " total"}, 128'(total_flips), 128'(tot[63:0]));
        chk({tag, " max"}, 128'(max_flips), 128'(mx));
        chk({tag, " max_row"}, 128'(max_row), 128'(mr));
    endtask

    typedef struct {
        int first, last, stride, nrec, mrow;
        logic [63:0] total, mx;
    } vec_t;
    vec_t vecs[8];

    initial begin
        vecs[0] = '{10, 12, 1, 3, 12, 64'd10, 64'd7};
        vecs[1] = '{5, 4, 1, 0, 0, 64'd0, 64'd0};
        vecs[2] = '{4094, 4095, 3, 1, 4094, 64'd4094, 64'd4094};
        vecs[3] = '{20, 30, 5, 3, 30, 64'd75, 64'd30};
        vecs[4] = '{7, 7, 0, 1, 7, 64'd7, 64'd7};
        vecs[5] = '{100, 103, 2, 2, 102, 64'd202, 64'd102};
        vecs[6] = '{40, 41, 1, 2, 40, 64'd18, 64'd9};
        vecs[7] = '{50, 51, 1, 2, 50, {64{1'b1}}, 64'hFFFF_FFFF_FFFF_FFF0};
        for (int r = 0; r < 4096; r++) begin
            flips_mem[r] = 64'(r);
            fin_mem[r] = 2;
        end
        flips_mem[10] = 3; flips_mem[11] = 0; flips_mem[12] = 7;
        flips_mem[40] = 9; flips_mem[41] = 9;
        flips_mem[50] = 64'hFFFF_FFFF_FFFF_FFF0; flips_mem[51] = 64'h20;

        repeat (3) tick;
        chk("rst busy", busy, 0);
        chk("rst test_reset", test_reset, 1);
        chk("rst test_address", test_address, 0);
        chk("rst outputs", {res_valid, res_row, res_flips, res_timeout, done}, 0);
        chk("rst stats", {total_flips, max_flips}, 0);
        chk("rst max_row", max_row, 0);
        reset = 1;
        tick;

        for (int v = 0; v < 8; v++) begin
            run_campaign(vecs[v].first, vecs[v].last, vecs[v].stride, 0, $sformatf("vec%0d", v));
            chk($sformatf("vec%0d tbl_records", v), got_q.size(), vecs[v].nrec);
            chk($sformatf("vec%0d tbl_total", v), total_flips, vecs[v].total);
            chk($sformatf("vec%0d tbl_max", v), max_flips, vecs[v].mx);
            chk($sformatf("vec%0d tbl_max_row", v), max_row, vecs[v].mrow);
        end

        fin_mem[60] = 0;
        fin_mem[61] = 3;
`ifdef HAMMER_CAMPAIGN_TIMEOUT_EN
        run_campaign(60, 60, 1, 20, "timeout20");
        chk("timeout20 flag", got_q.size() > 0 ? got_q[0].timeout : 1'b0, 1);
        run_campaign(61, 61, 1, 4, "finish_tie");
        run_campaign(61, 61, 1, 1, "timeout1");
`else
        launch(60, 60, 1, 20);
        repeat (100) tick;
        chk("no_timeout still_run", {busy, test_reset}, 2'b10);
        abort = 1;
        tick;
        abort = 0;
        chk("no_timeout abort_done", done, 1);
        tick;
        chk("no_timeout records", got_q.size(), 0);
`endif

        // consumer stalls the first record, then an abort lands mid-RUN
        rdy_val = 0;
        flips_mem[70] = 64'h1234;
        launch(70, 72, 1, 0);
        for (int i = 0; i < 50 && !res_valid; i++) tick;
        chk("stall valid_seen", res_valid, 1);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall hold%0d", i), {res_valid, res_row, res_flips, res_timeout},
                {1'b1, 12'd70, 64'h1234, 1'b0});
            chk($sformatf("stall addr%0d", i), test_address, exp_addr(base_address, 12'd70));
            tick;
        end
        rdy_val = 1;
        tick;
        chk("stall total", total_flips, 64'h1234);
        for (int i = 0; i < 50 && test_reset; i++) tick;
        chk("abort in_run", test_reset, 0);
        abort = 1;
        tick;
        abort = 0;
        chk("abort done", done, 1);
        tick;
        chk("abort idle", busy, 0);
        chk("abort records", got_q.size(), 1);
        chk("abort stats", {total_flips, max_flips, max_row}, {64'h1234, 64'h1234, 12'd70});

        // reset in the middle of a run
        launch(80, 82, 1, 0);
        for (int i = 0; i < 50 && total_flips == 0; i++) tick;
        for (int i = 0; i < 50 && test_reset; i++) tick;
        chk("midrst in_run", {test_reset, total_flips}, {1'b0, 64'd80});
        reset = 0;
        tick;
        chk("midrst state", {busy, test_reset, res_valid, done}, 4'b0100);
        chk("midrst stats", {total_flips, max_flips}, 0);
        chk("midrst max_row", {max_row, test_address}, 0);
        reset = 1;
        tick;

        rdy_rand = 1;
        for (int c = 0; c < 30; c++) begin
            int first, last;
            first = $urandom_range(0, 4095);
            last = first + int'($urandom_range(0, 12)) - 1;
            if (last > 4095) last = 4095;
            if (last < 0) last = 0;
            for (int r = first; r <= 4095 && r <= first + 16; r++) begin
                flips_mem[r] = ($urandom_range(0, 3) == 0) ? {1'b1, 31'($urandom), $urandom} : 64'($urandom_range(0, 1000));
                fin_mem[r] = $urandom_range(1, 8);
            end
            run_campaign(first, last, $urandom_range(0, 4), $urandom_range(0, 10), $sformatf("rnd%0d", c));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
